tcp_rx_cmd_parser: RTL and testbench

TCP_RX_CMD_PARSER -- requirements
Module: tcp_rx_cmd_parser

---
 rtl/tcp_rx_cmd_parser.sv | 152 +++++++++++++++
 tb/tb_tcp_rx_cmd_parser.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_rx_cmd_parser.sv
// tcp_rx_cmd_parser: turns framed write commands arriving on a TCP Rx FIFO
// (A5 | addr[31:0] | len[15:0] | data...) into single-byte bus writes.
// Build option: define TCP_RX_CMD_STATUS_EN to get the FRAME_CNT and
// SYNC_ERR_CNT status counters; without it both ports read as 0.
module tcp_rx_cmd_parser #(
  parameter int ABUSWIDTH = 32
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 USR_ACTIVE,
  input  logic                 USR_RX_EMPTY,
  output logic                 USR_RX_RE,
  input  logic                 USR_RX_RV,
  input  logic [7:0]           USR_RX_RD,
  output logic                 BUS_WR,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  output logic [7:0]           BUS_DATA,
  output logic [15:0]          FRAME_CNT,
  output logic [7:0]           SYNC_ERR_CNT
);

  // state | meaning
  // IDLE  | waiting for sync byte 0xA5, other bytes are dropped
  // ADDR  | collecting 4 address bytes, MSB first
  // LEN   | collecting 2 length bytes, MSB first
  // DATA  | one bus write per data byte until the length runs out
  typedef enum logic [1:0] {IDLE, ADDR, LEN, DATA} state_t;

  state_t                 state_q, state_d;
  logic                   rd_pending;
  logic [1:0]             fld_cnt;
  logic [31:0]            addr_q;
  logic [7:0]             len_hi;
  logic [15:0]            rem_q;
  logic [ABUSWIDTH-1:0]   cur_add;
  logic                   byte_ok;
  logic                   rd_issue;
  logic                   len_zero;

  // A byte counts only when it answers our single outstanding read; the
  // RE cycle itself is excluded so the FIFO's reply must come later.
  assign byte_ok  = USR_RX_RV && rd_pending && !USR_RX_RE && USR_ACTIVE;
  assign rd_issue = USR_ACTIVE && !USR_RX_EMPTY && !rd_pending;
  assign len_zero = ({len_hi, USR_RX_RD} == 16'd0);

  // State register.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode; a dropped connection abandons any partial frame.
  always_comb begin
    state_d = state_q;
    if (!USR_ACTIVE) begin
      state_d = IDLE;
    end else if (byte_ok) begin
      case (state_q)
        IDLE:    if (USR_RX_RD == 8'hA5) state_d = ADDR;
        ADDR:    if (fld_cnt == 2'd3) state_d = LEN;
        LEN:     if (fld_cnt == 2'd1) state_d = len_zero ? IDLE : DATA;
        DATA:    if (rem_q == 16'd1) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Read handshake: one RE pulse, then wait for the matching RV.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || !USR_ACTIVE) begin
      USR_RX_RE  <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      USR_RX_RE <= rd_issue;
      if (rd_issue)     rd_pending <= 1'b1;
      else if (byte_ok) rd_pending <= 1'b0;
    end
  end

  // Byte position inside the ADDR/LEN fields; restarts on every state change.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || state_d != state_q) fld_cnt <= 2'd0;
    else if (byte_ok)                  fld_cnt <= fld_cnt + 2'd1;
  end

  // Header capture and data-phase bookkeeping (remaining bytes count down).
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      addr_q  <= 32'd0;
      len_hi  <= 8'd0;
      rem_q   <= 16'd0;
      cur_add <= '0;
    end else if (byte_ok) begin
      case (state_q)
        ADDR: addr_q <= {addr_q[23:0], USR_RX_RD};
        LEN: begin
          if (fld_cnt == 2'd0) begin
            len_hi <= USR_RX_RD;
          end else begin
            rem_q   <= {len_hi, USR_RX_RD};
            cur_add <= ABUSWIDTH'(addr_q);
          end
        end
        DATA: begin
          rem_q   <= rem_q - 16'd1;
          cur_add <= cur_add + ABUSWIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Bus write one cycle after each data byte; address/data hold otherwise.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      BUS_WR   <= 1'b0;
      BUS_ADD  <= '0;
      BUS_DATA <= 8'd0;
    end else begin
      BUS_WR <= byte_ok && (state_q == DATA);
      if (byte_ok && (state_q == DATA)) begin
        BUS_ADD  <= cur_add;
        BUS_DATA <= USR_RX_RD;
      end
    end
  end

`ifdef TCP_RX_CMD_STATUS_EN
  logic frame_done;
  logic sync_bad;

  assign frame_done = byte_ok &&
                      ((state_q == LEN && fld_cnt == 2'd1 && len_zero) ||
                       (state_q == DATA && rem_q == 16'd1));
  assign sync_bad   = byte_ok && (state_q == IDLE) && (USR_RX_RD != 8'hA5);

  // Status counters: frames wrap, sync errors saturate.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      FRAME_CNT    <= 16'd0;
      SYNC_ERR_CNT <= 8'd0;
    end else begin
      if (frame_done) FRAME_CNT <= FRAME_CNT + 16'd1;
      if (sync_bad && SYNC_ERR_CNT != 8'hFF) SYNC_ERR_CNT <= SYNC_ERR_CNT + 8'd1;
    end
  end
`else
  assign FRAME_CNT    = 16'd0;
  assign SYNC_ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_tcp_rx_cmd_parser.sv
// Bench for tcp_rx_cmd_parser: FIFO responder with random RV latency,
// random EMPTY gaps and stray RV pulses, plus a frame-level reference model.
module tb_tcp_rx_cmd_parser;
  localparam int AW = 32;
`ifdef TCP_RX_CMD_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          active = 1'b1;
  logic          empty = 1'b1;
  logic          re;
  logic          rv = 1'b0;
  logic [7:0]    rd = 8'h00;
  logic          wr;
  logic [AW-1:0] add;
  logic [7:0]    data;
  logic [15:0]   frame_cnt;
  logic [7:0]    sync_cnt;

  always #5 clk = ~clk;

  tcp_rx_cmd_parser #(.ABUSWIDTH(AW)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .USR_ACTIVE(active), .USR_RX_EMPTY(empty),
    .USR_RX_RE(re), .USR_RX_RV(rv), .USR_RX_RD(rd), .BUS_WR(wr),
    .BUS_ADD(add), .BUS_DATA(data), .FRAME_CNT(frame_cnt), .SYNC_ERR_CNT(sync_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  fifo_q[$];
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  int          rd_cnt = 0;
  logic [7:0]  rd_byte = 8'h00;
  bit          re_prev = 1'b0;
  bit          empty_prev = 1'b1;
  bit          rand_mode = 1'b0;
  bit          deliver;
  int          proto_err = 0;
  int          hold_err = 0;
  int          m_frames = 0;
  int          m_sync = 0;
  logic [AW-1:0] last_add = '0;
  logic [7:0]    last_data = 8'h00;
  bit            rst_d = 1'b1;

  function automatic int en(input int x);
    return STATUS_EN ? x : 0;
  endfunction

  // FIFO responder: answers each RE with one byte 1..3 cycles later.
  always @(negedge clk) begin
    deliver = 1'b0;
    rv = 1'b0;
    rd = 8'($urandom);
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        rv = 1'b1;
        rd = rd_byte;
        deliver = 1'b1;
      end
    end
    if (re) begin
      if (rd_cnt > 0 || deliver || re_prev || empty_prev || !active) proto_err++;
      if (fifo_q.size() == 0) begin
        proto_err++;
      end else begin
        rd_byte = fifo_q.pop_front();
        rd_cnt  = rand_mode ? $urandom_range(1, 3) : 1;
      end
    end
    if (rand_mode && !deliver && !re && rd_cnt == 0 && $urandom_range(0, 7) == 0) rv = 1'b1;
    re_prev    = re;
    empty      = (fifo_q.size() == 0) || (rand_mode && $urandom_range(0, 2) == 0);
    empty_prev = empty;
  end

  // Bus monitor: collect writes and watch that address/data hold between writes.
  always @(negedge clk) begin
    if (wr) obs_q.push_back({add, data});
    else if (!rst && !rst_d && (add !== last_add || data !== last_data)) hold_err++;
    last_add  = add;
    last_data = data;
    rst_d     = rst;
  end

  // Reference model: walks a byte stream frame by frame.
  task automatic model(input logic [7:0] s[$]);
    int i = 0;
    int n;
    logic [31:0] a;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        if (m_sync < 255) m_sync++;
        i++;
      end else if (i + 6 >= s.size()) begin
        i = s.size();
      end else begin
        a = {s[i+1], s[i+2], s[i+3], s[i+4]};
        n = int'({s[i+5], s[i+6]});
        for (int k = 0; k < n && i + 7 + k < s.size(); k++)
          exp_q.push_back({a + 32'(k), s[i+7+k]});
        if (i + 7 + n <= s.size()) m_frames++;
        i += 7 + n;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
  endtask

  task automatic run(input logic [7:0] s[$]);
    int idle = 0;
    int t = 0;
    foreach (s[j]) fifo_q.push_back(s[j]);
    while (idle < 6 && t < 20000) begin
      @(posedge clk); #1;
      t++;
      if (fifo_q.size() == 0 && rd_cnt == 0 && !re) idle++;
      else idle = 0;
    end
    if (idle < 6) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d bytes still queued, expected 0", fifo_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (re !== 1'b0)   begin n_err++; $display("FAIL reset_re: got %b want 0", re); end
    n_cmp++; if (wr !== 1'b0)   begin n_err++; $display("FAIL reset_wr: got %b want 0", wr); end
    n_cmp++; if (add !== '0)    begin n_err++; $display("FAIL reset_add: got %h want 0", add); end
    n_cmp++; if (data !== 8'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data); end
    n_cmp++; if (frame_cnt !== 16'h0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (sync_cnt !== 8'h0)   begin n_err++; $display("FAIL reset_sync_cnt: got %0d want 0", sync_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0]  s[$];
    logic [39:0] want[$];
    do_reset();
    s    = '{8'hA5, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    want = '{{32'h8000, 8'h11}, {32'h8001, 8'h22}, {32'h8002, 8'h33}};
    run(s);
    n_cmp++;
    if (obs_q.size() != want.size()) begin n_err++; $display("FAIL basic_count: got %0d writes want %0d", obs_q.size(), want.size()); end
    foreach (want[j]) if (j < obs_q.size()) begin
      n_cmp++;
      if (obs_q[j] !== want[j]) begin n_err++; $display("FAIL basic_wr[%0d]: got %h want %h", j, obs_q[j], want[j]); end
    end
    n_cmp++; if (frame_cnt !== 16'(en(1))) begin n_err++; $display("FAIL basic_frame_cnt: got %0d want %0d", frame_cnt, en(1)); end
  endtask

  task automatic test_sync();
    logic [7:0]  s[$];
    logic [39:0] want[$];
    do_reset();
    s    = '{8'h5A, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 8'h7E};
    want = '{{32'h10, 8'h7E}};
    run(s);
    n_cmp++;
    if (obs_q.size() != want.size()) begin n_err++; $display("FAIL sync_count: got %0d writes want %0d", obs_q.size(), want.size()); end
    foreach (want[j]) if (j < obs_q.size()) begin
      n_cmp++;
      if (obs_q[j] !== want[j]) begin n_err++; $display("FAIL sync_wr[%0d]: got %h want %h", j, obs_q[j], want[j]); end
    end
    n_cmp++; if (sync_cnt !== 8'(en(2)))   begin n_err++; $display("FAIL sync_err_cnt: got %0d want %0d", sync_cnt, en(2)); end
    n_cmp++; if (frame_cnt !== 16'(en(1))) begin n_err++; $display("FAIL sync_frame_cnt: got %0d want %0d", frame_cnt, en(1)); end
  endtask

  task automatic test_wrap();
    logic [7:0]  s[$];
    logic [39:0] want[$];
    do_reset();
    s    = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB};
    want = '{{32'hFFFF_FFFF, 8'hAA}, {32'h0000_0000, 8'hBB}};
    run(s);
    n_cmp++;
    if (obs_q.size() != want.size()) begin n_err++; $display("FAIL wrap_count: got %0d writes want %0d", obs_q.size(), want.size()); end
    foreach (want[j]) if (j < obs_q.size()) begin
      n_cmp++;
      if (obs_q[j] !== want[j]) begin n_err++; $display("FAIL wrap_wr[%0d]: got %h want %h", j, obs_q[j], want[j]); end
    end
  endtask

  task automatic test_zero_len();
    logic [7:0]  s[$];
    logic [39:0] want[$];
    do_reset();
    s = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run(s);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL zero_len_writes: got %0d want 0", obs_q.size()); end
    n_cmp++; if (frame_cnt !== 16'(en(1))) begin n_err++; $display("FAIL zero_len_frame_cnt: got %0d want %0d", frame_cnt, en(1)); end
    s    = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h66};
    want = '{{32'h5, 8'h66}};
    run(s);
    n_cmp++;
    if (obs_q.size() != want.size()) begin n_err++; $display("FAIL zero_len_next_count: got %0d writes want %0d", obs_q.size(), want.size()); end
    foreach (want[j]) if (j < obs_q.size()) begin
      n_cmp++;
      if (obs_q[j] !== want[j]) begin n_err++; $display("FAIL zero_len_next_wr[%0d]: got %h want %h", j, obs_q[j], want[j]); end
    end
    n_cmp++; if (frame_cnt !== 16'(en(2))) begin n_err++; $display("FAIL zero_len_next_frame_cnt: got %0d want %0d", frame_cnt, en(2)); end
  endtask

  task automatic test_abort();
    logic [7:0]  s[$];
    logic [39:0] want[$];
    do_reset();
    s = '{8'hA5, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02};
    run(s);
    active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    active = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (obs_q.size() != 2) begin n_err++; $display("FAIL abort_writes: got %0d want 2", obs_q.size()); end
    n_cmp++; if (frame_cnt !== 16'(en(0))) begin n_err++; $display("FAIL abort_frame_cnt: got %0d want %0d", frame_cnt, en(0)); end
    s    = '{8'hA5, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h5C};
    want = '{{32'h2000, 8'h01}, {32'h2001, 8'h02}, {32'h3000, 8'h5C}};
    run(s);
    n_cmp++;
    if (obs_q.size() != want.size()) begin n_err++; $display("FAIL abort_count: got %0d writes want %0d", obs_q.size(), want.size()); end
    foreach (want[j]) if (j < obs_q.size()) begin
      n_cmp++;
      if (obs_q[j] !== want[j]) begin n_err++; $display("FAIL abort_wr[%0d]: got %h want %h", j, obs_q[j], want[j]); end
    end
    n_cmp++; if (frame_cnt !== 16'(en(1))) begin n_err++; $display("FAIL abort_next_frame_cnt: got %0d want %0d", frame_cnt, en(1)); end
    n_cmp++; if (sync_cnt !== 8'(en(0)))   begin n_err++; $display("FAIL abort_sync_cnt: got %0d want %0d", sync_cnt, en(0)); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] s[$];
    int wr_seen = 0;
    do_reset();
    s = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h44};
    run(s);
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== {32'h100, 8'h44}) begin
      n_err++; $display("FAIL midrst_first_wr: got %0d writes want 1 write of 00000100/44", obs_q.size());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    for (int c = 0; c < 4; c++) begin
      if (wr) wr_seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (wr_seen != 0) begin n_err++; $display("FAIL midrst_wr_after: got %0d pulses want 0", wr_seen); end
    n_cmp++; if (add !== '0 || data !== 8'h0) begin n_err++; $display("FAIL midrst_bus: got %h/%h want 0/0", add, data); end
    s = '{8'h11, 8'h22};
    run(s);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL midrst_leftover_writes: got %0d want 0", obs_q.size()); end
    n_cmp++; if (sync_cnt !== 8'(en(2)))   begin n_err++; $display("FAIL midrst_sync_cnt: got %0d want %0d", sync_cnt, en(2)); end
    n_cmp++; if (frame_cnt !== 16'(en(0))) begin n_err++; $display("FAIL midrst_frame_cnt: got %0d want %0d", frame_cnt, en(0)); end
  endtask

  task automatic test_sync_saturate();
    logic [7:0] s[$];
    logic [7:0] b;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      s.push_back(b);
    end
    s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00);
    s.push_back(8'h40); s.push_back(8'h00); s.push_back(8'h01); s.push_back(8'h99);
    run(s);
    n_cmp++; if (sync_cnt !== 8'(en(255))) begin n_err++; $display("FAIL sat_sync_cnt: got %0d want %0d", sync_cnt, en(255)); end
    n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== {32'h40, 8'h99}) begin
      n_err++; $display("FAIL sat_wr: got %0d writes want 1 write of 00000040/99", obs_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0]  s[$];
    logic [7:0]  b;
    logic [31:0] a;
    int          n;
    do_reset();
    exp_q.delete();
    m_frames = 0;
    m_sync   = 0;
    for (int f = 0; f < 8; f++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        s.push_back(b);
      end
      a = $urandom;
      n = $urandom_range(0, 5);
      s.push_back(8'hA5);
      s.push_back(a[31:24]); s.push_back(a[23:16]); s.push_back(a[15:8]); s.push_back(a[7:0]);
      s.push_back(8'h00); s.push_back(8'(n));
      for (int k = 0; k < n; k++) s.push_back(8'($urandom_range(0, 255)));
    end
    model(s);
    rand_mode = 1'b1;
    run(s);
    rand_mode = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_cmp++;
      if (obs_q[j] !== exp_q[j]) begin n_err++; $display("FAIL random_wr[%0d]: got %h want %h", j, obs_q[j], exp_q[j]); end
    end
    n_cmp++; if (frame_cnt !== 16'(en(m_frames))) begin n_err++; $display("FAIL random_frame_cnt: got %0d want %0d", frame_cnt, en(m_frames)); end
    n_cmp++; if (sync_cnt !== 8'(en(m_sync)))     begin n_err++; $display("FAIL random_sync_cnt: got %0d want %0d", sync_cnt, en(m_sync)); end
  endtask

  task automatic test_protocol();
    n_cmp++; if (proto_err != 0) begin n_err++; $display("FAIL read_protocol: got %0d bad RE pulses want 0", proto_err); end
    n_cmp++; if (hold_err != 0)  begin n_err++; $display("FAIL bus_hold: got %0d changes without BUS_WR want 0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sync();
    test_wrap();
    test_zero_len();
    test_abort();
    test_reset_mid_frame();
    test_sync_saturate();
    test_random();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
